// File: rtl/flick_conditioner.sv
// flick_conditioner
//   Front end for the LED flasher's flick button. The raw button is brought into
//   the clk domain through a flop chain and then debounced by a small FSM.
//   Each accepted press produces exactly one single-cycle pulse. A debounced
//   level is also provided. Rising glitches that are rejected are counted,
//   and the count saturates.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     flick_raw    raw button input, asynchronous and may bounce
//     flick_pulse  one-cycle pulse per accepted press (registered)
//     flick_level  debounced button level (registered)
//     glitch_cnt   saturating count of rejected rising glitches
//
//   Parameter constraints: SYNC_STAGES >= 2, DB_CYCLES >= 1, and
//   DB_CYCLES <= 2**CNT_W-1.
module flick_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 3,
    parameter int GC_W        = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flick_raw,
    output logic            flick_pulse,
    output logic            flick_level,
    output logic [GC_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {IDLE, RISE_CHK, HIGH, FALL_CHK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES);
    localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pulse_q;
    logic                   level_q;
    logic [GC_W-1:0]        gc_q;
    logic [GC_W-1:0]        gc_d;

    // The synchroniser shifts toward the MSB. Only the last stage is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], flick_raw};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // The glitch counter holds at all-ones and does not wrap.
    assign gc_d = (gc_q == '1) ? gc_q : gc_q + GC_ONE;

    // cnt_q counts the stable samples seen so far in a CHK state.
    // The first sample is counted on entry, so DB_CYCLES+1 agreeing samples
    // are needed to cross.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            gc_q    <= '0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        state_q <= RISE_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RISE_CHK: begin
                    if (!sync) begin
                        state_q <= IDLE;
                        gc_q    <= gc_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync) begin
                        state_q <= FALL_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                FALL_CHK: begin
                    // A bounce on release returns to HIGH. It is not a new
                    // press and it is not a glitch.
                    if (sync) begin
                        state_q <= HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flick_pulse = pulse_q;
    assign flick_level = level_q;
    assign glitch_cnt  = gc_q;

endmodule
